// File: rtl/exu_oitf_pkg.sv
// Shared widths and entry payload type for the outstanding instruction track FIFO.
// Macro defaults stand in for the core-wide defines when they are not supplied.
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef OITF_DEPTH
`define OITF_DEPTH 2
`endif

package exu_oitf_pkg;

  localparam int RFIDX_W   = `RFIDX_WIDTH;
  localparam int PC_W      = `PC_SIZE;
  localparam int DEPTH_DEF = `OITF_DEPTH;

  typedef struct packed {
    logic               rdwen;
    logic [RFIDX_W-1:0] rdidx;
    logic [PC_W-1:0]    pc;
  } oitf_entry_t;

  // An entry hazards against a register only if it is live and really writes rd.
  function automatic logic rd_hit(input logic vld, input oitf_entry_t ent,
                                  input logic [RFIDX_W-1:0] idx);
    return vld & ent.rdwen & (ent.rdidx == idx);
  endfunction

endpackage

// File: rtl/exu_oitf_ptr.sv
// Wrap-flag FIFO pointer: low bits index the entry, MSB toggles on each wrap.
module exu_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc,
  output logic [PTR_W:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr[PTR_W-1:0] == PTR_W'(DEPTH - 1)) begin
        ptr <= {~ptr[PTR_W], {PTR_W{1'b0}}};
      end else begin
        ptr <= ptr + (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO for long-pipe ops: allocation at dispatch,
// in-order retire at writeback, and RAW/WAW hazard flags back to dispatch.
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef OITF_DEPTH
`define OITF_DEPTH 2
`endif

module exu_oitf
  import exu_oitf_pkg::*;
#(
  parameter int DEPTH = `OITF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dis_ena,
  output logic                    dis_ready,
  input  logic                    disp_i_rdwen,
  input  logic [`RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic [`PC_SIZE-1:0]     disp_i_pc,
  input  logic                    disp_i_rs1en,
  input  logic                    disp_i_rs2en,
  input  logic [`RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [`RFIDX_WIDTH-1:0] disp_i_rs2idx,
  output logic                    oitfrd_match_disprs1,
  output logic                    oitfrd_match_disprs2,
  output logic                    oitfrd_match_disprd,
  output logic [PTR_W-1:0]        dis_ptr,
  input  logic                    oitf_ret_ena,
  output logic                    oitf_ret_rdwen,
  output logic [`RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic [`PC_SIZE-1:0]     oitf_ret_pc,
  output logic [PTR_W-1:0]        ret_ptr,
  output logic                    oitf_empty
);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             wr_ena;
  logic             rd_ena;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] hit_rs1;
  logic [DEPTH-1:0] hit_rs2;
  logic [DEPTH-1:0] hit_rd;
  oitf_entry_t      ent [DEPTH];
  oitf_entry_t      dis_ent;
  oitf_entry_t      ret_ent;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                  (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  // Illegal requests are dropped here so the FIFO state can never corrupt.
  assign wr_ena = dis_ena & ~full;
  assign rd_ena = oitf_ret_ena & ~empty;

  exu_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_ena),
    .ptr   (wr_ptr)
  );

  exu_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_ena),
    .ptr   (rd_ptr)
  );

  assign dis_ent.rdwen = disp_i_rdwen;
  assign dis_ent.rdidx = disp_i_rdidx;
  assign dis_ent.pc    = disp_i_pc;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic        vld_q;
    oitf_entry_t ent_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        ent_q <= '0;
      end else if (wr_ena && (wr_ptr[PTR_W-1:0] == PTR_W'(i))) begin
        vld_q <= 1'b1;
        ent_q <= dis_ent;
      end else if (rd_ena && (rd_ptr[PTR_W-1:0] == PTR_W'(i))) begin
        vld_q <= 1'b0;
      end
    end

    assign vld[i]     = vld_q;
    assign ent[i]     = ent_q;
    assign hit_rs1[i] = rd_hit(vld_q, ent_q, disp_i_rs1idx);
    assign hit_rs2[i] = rd_hit(vld_q, ent_q, disp_i_rs2idx);
    assign hit_rd[i]  = rd_hit(vld_q, ent_q, disp_i_rdidx);
  end

  // A retiring entry is still in hit_* this cycle, which keeps the flags conservative.
  assign oitfrd_match_disprs1 = disp_i_rs1en & (|hit_rs1);
  assign oitfrd_match_disprs2 = disp_i_rs2en & (|hit_rs2);
  assign oitfrd_match_disprd  = disp_i_rdwen & (|hit_rd);

  assign ret_ent        = ent[rd_ptr[PTR_W-1:0]];
  assign oitf_ret_rdwen = ret_ent.rdwen;
  assign oitf_ret_rdidx = ret_ent.rdidx;
  assign oitf_ret_pc    = ret_ent.pc;

  assign dis_ptr    = wr_ptr[PTR_W-1:0];
  assign ret_ptr    = rd_ptr[PTR_W-1:0];
  assign dis_ready  = ~full;
  assign oitf_empty = empty;

  a_no_dis_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(dis_ena && full))
    else $warning("exu_oitf: dispatch while full, request dropped");

  a_no_ret_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(oitf_ret_ena && empty))
    else $warning("exu_oitf: retire while empty, request dropped");

  // vld is kept for visibility of the occupancy map; it feeds the hit terms directly.
  logic unused_vld;
  assign unused_vld = ^vld;

endmodule
